// File: rtl/alu_wb_stage.sv
// ---------------------------------------------------------------------------
// alu_wb_stage
//
// Writeback stage behind the ALU. Ops pass through a two-entry skid buffer
// (main, skid). The ALU flag register is written when an op is accepted, so
// the next ALU op sees the new carry even while its predecessor is stalled.
//
// Ports
//   i_clk, i_rst         clock; synchronous active-high reset
//   in_valid/in_ready    upstream handshake. in_ready = !skid_valid, which
//                        comes from registered state only
//   in_result[15:0]      ALU result
//   in_flags[7:0]        ALU flags (only [4:0] are architectural)
//   in_rd[2:0]           destination register
//   in_wr_en             register write request
//   in_flag_en           flag update request
//   out_valid/out_ready  downstream handshake (out_valid = main_valid)
//   out_result, out_rd,  retiring op, held stable while stalled
//   out_wr_en
//   flags_q[7:0]         architectural flags, bits [7:5] tied to 0
//   carry_q              flags_q[1], fed back to the ALU carry input
//   sys_flag_we,         flag restore; wins over an accept-time update
//   sys_flag_data[7:0]
//   i_flush              drops both buffered ops and any same-cycle accept
//   retire_cnt[15:0]     retired-op counter, wraps at 2^16
// ---------------------------------------------------------------------------
module alu_wb_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_result,
    input  logic [7:0]  in_flags,
    input  logic [2:0]  in_rd,
    input  logic        in_wr_en,
    input  logic        in_flag_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [2:0]  out_rd,
    output logic        out_wr_en,
    output logic [7:0]  flags_q,
    output logic        carry_q,
    input  logic        sys_flag_we,
    input  logic [7:0]  sys_flag_data,
    input  logic        i_flush,
    output logic [15:0] retire_cnt
);

    logic        main_valid;
    logic [15:0] main_result;
    logic [2:0]  main_rd;
    logic        main_wr_en;

    logic        skid_valid;
    logic [15:0] skid_result;
    logic [2:0]  skid_rd;
    logic        skid_wr_en;

    // Only five flag bits exist; the upper three are constant zero.
    logic [4:0]  flag_bits;
    logic [15:0] retire_cnt_r;

    logic        accept;
    logic        retire;

    // Upper flag bits are architecturally absent and deliberately ignored.
    logic        unused_flag_bits;
    assign unused_flag_bits = ^{in_flags[7:5], sys_flag_data[7:5]};

    assign in_ready   = ~skid_valid;
    assign accept     = in_valid & in_ready;
    assign retire     = main_valid & out_ready;

    assign out_valid  = main_valid;
    assign out_result = main_result;
    assign out_rd     = main_rd;
    assign out_wr_en  = main_wr_en;

    assign flags_q    = {3'b000, flag_bits};
    assign carry_q    = flag_bits[1];
    assign retire_cnt = retire_cnt_r;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_valid   <= 1'b0;
            main_result  <= 16'h0000;
            main_rd      <= 3'd0;
            main_wr_en   <= 1'b0;
            skid_valid   <= 1'b0;
            skid_result  <= 16'h0000;
            skid_rd      <= 3'd0;
            skid_wr_en   <= 1'b0;
            flag_bits    <= 5'd0;
            retire_cnt_r <= 16'h0000;
        end else begin
            // A flushed accept never happened, so its flag update is dropped.
            if (sys_flag_we) begin
                flag_bits <= sys_flag_data[4:0];
            end else if (accept && in_flag_en && !i_flush) begin
                flag_bits <= in_flags[4:0];
            end

            if (retire && !i_flush) begin
                retire_cnt_r <= retire_cnt_r + 16'd1;
            end

            if (i_flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (retire && skid_valid) begin
                // Skid moves up; a new accept (if any) refills skid.
                main_result <= skid_result;
                main_rd     <= skid_rd;
                main_wr_en  <= skid_wr_en;
                skid_valid  <= accept;
                if (accept) begin
                    skid_result <= in_result;
                    skid_rd     <= in_rd;
                    skid_wr_en  <= in_wr_en;
                end
            end else if (main_valid && !retire) begin
                // Main is stalled: an accept lands in skid.
                if (accept) begin
                    skid_valid  <= 1'b1;
                    skid_result <= in_result;
                    skid_rd     <= in_rd;
                    skid_wr_en  <= in_wr_en;
                end
            end else begin
                // Main empty, or main retiring with skid empty.
                main_valid <= accept;
                if (accept) begin
                    main_result <= in_result;
                    main_rd     <= in_rd;
                    main_wr_en  <= in_wr_en;
                end
            end
        end
    end

endmodule
